// File: rtl/cache_refill.sv
// cache_refill: single-outstanding miss engine between a direct-mapped cache and the memory bus.
// Define REFILL_PREFETCH_EN to also fetch the next sequential word after each refill.
module cache_refill #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_miss,
  input  logic [31:0] i_miss_addr,
  output logic        o_busy,
  output logic        o_fill_wen,
  output logic [31:0] o_fill_addr,
  output logic [31:0] o_fill_data,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_err
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] REQ     = 4'd1;
  localparam logic [3:0] WAIT    = 4'd2;
  localparam logic [3:0] FILL    = 4'd3;
  localparam logic [3:0] HOLD    = 4'd4;
  localparam logic [3:0] ERR     = 4'd5;
`ifdef REFILL_PREFETCH_EN
  localparam logic [3:0] PF_REQ  = 4'd6;
  localparam logic [3:0] PF_WAIT = 4'd7;
  localparam logic [3:0] PF_FILL = 4'd8;
  localparam logic [3:0] PF_HOLD = 4'd9;
`endif

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] TO_MAX = '1;

  logic [3:0]      state;
  logic [3:0]      nxt;
  logic [31:0]     addr_q;
  logic [31:0]     data_q;
  logic [TO_W-1:0] timer;
  logic            in_req;
  logic            in_wait;
  logic            in_fill;
  logic            tmo;
  logic            unused_addr;

  assign unused_addr = ^i_miss_addr[1:0];

`ifdef REFILL_PREFETCH_EN
  logic last_word;

  // no prefetch past the top of the address space
  assign last_word = (addr_q == 32'hFFFF_FFFC);
  assign in_req    = (state == REQ)  || (state == PF_REQ);
  assign in_wait   = (state == WAIT) || (state == PF_WAIT);
  assign in_fill   = (state == FILL) || (state == PF_FILL);
`else
  assign in_req    = (state == REQ);
  assign in_wait   = (state == WAIT);
  assign in_fill   = (state == FILL);
`endif

  // >= also covers a grant landing exactly on the limit
  assign tmo = (timer >= TO_LIM);

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (i_miss) nxt = REQ;
      end
      REQ: begin
        if (i_mem_gnt)  nxt = WAIT;
        else if (tmo)   nxt = ERR;
      end
      WAIT: begin
        if (i_mem_rvalid) nxt = FILL;
        else if (tmo)     nxt = ERR;
      end
      FILL: nxt = HOLD;
`ifdef REFILL_PREFETCH_EN
      HOLD: nxt = last_word ? IDLE : PF_REQ;
      PF_REQ: begin
        if (i_mem_gnt)  nxt = PF_WAIT;
        else if (tmo)   nxt = ERR;
      end
      PF_WAIT: begin
        if (i_mem_rvalid) nxt = PF_FILL;
        else if (tmo)     nxt = ERR;
      end
      PF_FILL: nxt = PF_HOLD;
      PF_HOLD: nxt = IDLE;
`else
      HOLD: nxt = IDLE;
`endif
      ERR:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      timer  <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && i_miss) begin
        addr_q <= {i_miss_addr[31:2], 2'b00};
        timer  <= '0;
      end else if (in_req || in_wait) begin
        if (timer != TO_MAX) timer <= timer + 1'b1;
      end
`ifdef REFILL_PREFETCH_EN
      else if (state == HOLD && !last_word) begin
        addr_q <= addr_q + 32'd4;
        timer  <= '0;
      end
`endif
      if (in_wait && i_mem_rvalid) data_q <= i_mem_rdata;
    end
  end

  assign o_busy      = (state != IDLE);
  assign o_mem_req   = in_req;
  assign o_mem_addr  = in_req  ? addr_q : 32'd0;
  assign o_fill_wen  = in_fill;
  assign o_fill_addr = in_fill ? addr_q : 32'd0;
  assign o_fill_data = in_fill ? data_q : 32'd0;
  assign o_err       = (state == ERR);

endmodule
